// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and op classification for the multiply/divide unit.
// MDU_MADD_EN enables the multiply-accumulate/subtract op class.
package mdu_pkg;

   localparam logic [3:0] MDU_MULT  = 4'd0;
   localparam logic [3:0] MDU_MULTU = 4'd1;
   localparam logic [3:0] MDU_DIV   = 4'd2;
   localparam logic [3:0] MDU_DIVU  = 4'd3;
   localparam logic [3:0] MDU_MTHI  = 4'd4;
   localparam logic [3:0] MDU_MTLO  = 4'd5;
   localparam logic [3:0] MDU_MADD  = 4'd6;
   localparam logic [3:0] MDU_MADDU = 4'd7;
   localparam logic [3:0] MDU_MSUB  = 4'd8;
   localparam logic [3:0] MDU_MSUBU = 4'd9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // Ops that occupy the engine for a fixed number of cycles.
   function automatic logic is_timed_op(input logic [3:0] op);
      logic r;
      r = (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
      r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
      return r;
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result path: {hi,lo} from latched op/operands and current HI/LO.
// Accumulating ops are only built when MDU_MADD_EN is defined.
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2*WIDTH-1:0]       w_a_sx, w_b_sx, w_a_zx, w_b_zx;
   logic [2*WIDTH-1:0]       w_prod_s, w_prod_u, w_res;
   logic signed [WIDTH-1:0]  w_q_s, w_r_s;
   logic [WIDTH-1:0]         w_q_u, w_r_u;
   logic                     w_b_zero, w_div_ovf;

   // Lower 2W bits of a 2W x 2W product of sign-extended operands is the signed product.
   assign w_a_sx   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_b_sx   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign w_a_zx   = {{WIDTH{1'b0}}, i_a};
   assign w_b_zx   = {{WIDTH{1'b0}}, i_b};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = w_a_zx * w_b_zx;

   assign w_b_zero  = (i_b == '0);
   assign w_div_ovf = (i_a == MOST_NEG) && (i_b == '1);
   assign w_q_s     = $signed(i_a) / $signed(i_b);
   assign w_r_s     = $signed(i_a) % $signed(i_b);
   assign w_q_u     = i_a / i_b;
   assign w_r_u     = i_a % i_b;

   always_comb begin
      w_res = {i_hi, i_lo};
      case (i_op)
         MDU_MULT:  w_res = w_prod_s;
         MDU_MULTU: w_res = w_prod_u;
         MDU_DIV: begin
            if (w_div_ovf)
               w_res = {{WIDTH{1'b0}}, MOST_NEG};
            else if (!w_b_zero)
               w_res = {w_r_s, w_q_s};
         end
         MDU_DIVU: begin
            if (!w_b_zero)
               w_res = {w_r_u, w_q_u};
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  w_res = {i_hi, i_lo} + w_prod_s;
         MDU_MADDU: w_res = {i_hi, i_lo} + w_prod_u;
         MDU_MSUB:  w_res = {i_hi, i_lo} - w_prod_s;
         MDU_MSUBU: w_res = {i_hi, i_lo} - w_prod_u;
`endif
         default:   w_res = {i_hi, i_lo};
      endcase
   end

   assign o_hi = w_res[2*WIDTH-1:WIDTH];
   assign o_lo = w_res[WIDTH-1:0];

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers, fixed latencies and busy/done.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   mdu_state_e       r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [3:0]       r_op, w_op_next;
   logic [WIDTH-1:0] r_a, w_a_next, r_b, w_b_next;
   logic [WIDTH-1:0] r_hi, w_hi_next, r_lo, w_lo_next;
   logic             r_done, w_done_next;
   logic [WIDTH-1:0] w_calc_hi, w_calc_lo;

   mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .i_op (r_op),
      .i_a  (r_a),
      .i_b  (r_b),
      .i_hi (r_hi),
      .i_lo (r_lo),
      .o_hi (w_calc_hi),
      .o_lo (w_calc_lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_op    <= w_op_next;
         r_a     <= w_a_next;
         r_b     <= w_b_next;
         r_hi    <= w_hi_next;
         r_lo    <= w_lo_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_op_next    = r_op;
      w_a_next     = r_a;
      w_b_next     = r_b;
      w_hi_next    = r_hi;
      w_lo_next    = r_lo;
      w_done_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (is_timed_op(op)) begin
                  w_state_next = ST_RUN;
                  w_op_next    = op;
                  w_a_next     = A;
                  w_b_next     = B;
                  w_cnt_next   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               end else if (op == MDU_MTHI) begin
                  w_hi_next = A;
               end else if (op == MDU_MTLO) begin
                  w_lo_next = A;
               end
            end
         end
         ST_RUN: begin
            // Any start here is dropped; the hazard unit is expected to stall.
            w_cnt_next = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_hi_next    = w_calc_hi;
               w_lo_next    = w_calc_lo;
               w_done_next  = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign busy = (r_state == ST_RUN);
   assign done = r_done;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu; expectations follow MDU_MADD_EN when defined.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] HI, LO;

   int n_checks = 0;
   int n_errors = 0;

   mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge, then scramble operands to prove they were latched.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      tick();
      start = 1'b0;
      A     = 32'hDEAD_BEEF;
      B     = 32'h0BAD_F00D;
   endtask

   task automatic wait_done(input string tag, input int exp_n,
                            input logic [31:0] eh, input logic [31:0] el);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_hi"}, 64'(HI), 64'(eh));
      chk({tag, "_lo"}, 64'(LO), 64'(el));
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 4'd0;
      A     = '0;
      B     = '0;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(HI), 64'd0);
      chk("rst_lo", 64'(LO), 64'd0);
      reset = 1'b1;
      tick();

      issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
      chk("mult_busy_start", 64'(busy), 64'd1);
      wait_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      tick();
      chk("mult_done_pulse", 64'(done), 64'd0);

      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_done("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
      tick();

      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_neg7_2", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      tick();

      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);
      tick();

      issue(MDU_DIVU, 32'd100, 32'd7);
      wait_done("divu", 10, 32'd2, 32'd14);
      tick();

      issue(MDU_MTHI, 32'h0000_1234, 32'd0);
      chk("mthi_idle_hi", 64'(HI), 64'h1234);
      chk("mthi_idle_busy", 64'(busy), 64'd0);
      chk("mthi_idle_done", 64'(done), 64'd0);

      issue(MDU_MTHI, 32'h0000_0011, 32'd0);
      issue(MDU_MTLO, 32'h0000_0022, 32'd0);
      chk("mtlo_lo", 64'(LO), 64'h22);
      issue(MDU_DIVU, 32'd55, 32'd0);
      wait_done("divu_zero", 10, 32'h0000_0011, 32'h0000_0022);
      tick();

      issue(4'hF, 32'd1, 32'd1);
      chk("undef_busy", 64'(busy), 64'd0);
      chk("undef_hilo", {32'(HI), 32'(LO)}, {32'h11, 32'h22});

      // MTHI while running is dropped; next MULT issued in the done cycle.
      issue(MDU_MULT, 32'd3, 32'd4);
      issue(MDU_MTHI, 32'h0000_1234, 32'd0);
      chk("mthi_run_hi", 64'(HI), 64'h11);
      wait_done("mult_3x4", 4, 32'd0, 32'd12);
      issue(MDU_MULT, 32'hFFFF_FFFD, 32'd6);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_done_low", 64'(done), 64'd0);
      wait_done("b2b_mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFEE);
      tick();

      // Asynchronous reset mid-run.
      issue(MDU_MULT, 32'd3, 32'd4);
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hilo", {32'(HI), 32'(LO)}, 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midrst_no_done", 64'(done | busy), 64'd0);
      end

      issue(MDU_MTHI, 32'd0, 32'd0);
      issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
      issue(MDU_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      wait_done("maddu", 5, 32'd1, 32'd0);
      tick();
      issue(MDU_MSUB, 32'd2, 32'hFFFF_FFFF);
      wait_done("msub", 5, 32'd1, 32'd2);
`else
      chk("maddu_off_busy", 64'(busy), 64'd0);
      tick();
      chk("maddu_off_done", 64'(done), 64'd0);
      chk("maddu_off_hilo", {32'(HI), 32'(LO)}, {32'd0, 32'hFFFF_FFFF});
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
